// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared encodings for the memory bus sequencer and lane aligner
package mips_mem_pkg;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  typedef enum logic [1:0] {IDLE, ACCESS, RELEASE} state_t;
  typedef enum logic {FETCH, DATA} grant_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: big-endian store lane placement and load extraction/extension
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  be,
  output logic [31:0] lane_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);
  logic [7:0]  b;
  logic [15:0] h;
  // byte lane 0 sits in bits 31:24, so lane n is shifted down by 8*(3-n)
  always_comb begin
    be = st_size == SZ_BYTE ? 4'b1000 >> st_lo :
         st_size == SZ_HALF ? (st_lo[1] ? 4'b0011 : 4'b1100) : 4'b1111;
    lane_wdata = st_size == SZ_BYTE ? {4{st_wdata[7:0]}} :
                 st_size == SZ_HALF ? {2{st_wdata[15:0]}} : st_wdata;
    b = 8'(ld_rdata >> {~ld_lo, 3'b000});
    h = ld_lo[1] ? ld_rdata[15:0] : ld_rdata[31:16];
    ld_data = ld_size == SZ_BYTE ? {{24{~ld_unsigned & b[7]}}, b} :
              ld_size == SZ_HALF ? {{16{~ld_unsigned & h[15]}}, h} : ld_rdata;
  end
endmodule

// File: rtl/mem_bus_sequencer.sv
// mem_bus_sequencer: arbitrates fetch and data paths onto one RAM port with moc handshake and timeout
module mem_bus_sequencer
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        ram_en,
  output logic        ram_rw,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_be,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        moc,
  output logic        busy
);
  state_t           state;
  grant_t           last_grant, gnt_q;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       sz_q, lo_q, st_size, st_lo;
  logic             uns_q, fetch_win, bad, go;
  logic [3:0]       be;
  logic [31:0]      lane_wdata, ld_data;

  // grant selection and legality of the request that would win this cycle
  always_comb begin
    fetch_win = if_req & (~d_req | last_grant == DATA);
    bad = fetch_win ? |if_addr[1:0] :
          d_size == 2'b11 | (d_size == SZ_WORD & |d_addr[1:0]) | (d_size == SZ_HALF & d_addr[0]);
    go = (if_req | d_req) & ~if_err & ~d_err;
    st_size = fetch_win ? SZ_WORD : d_size;
    st_lo = fetch_win ? 2'b00 : d_addr[1:0];
  end

  mem_lane_align u_align (
    .st_size    (st_size),
    .st_lo      (st_lo),
    .st_wdata   (d_wdata),
    .be         (be),
    .lane_wdata (lane_wdata),
    .ld_size    (sz_q),
    .ld_lo      (lo_q),
    .ld_unsigned(uns_q),
    .ld_rdata   (ram_rdata),
    .ld_data    (ld_data)
  );

  // sequencer FSM; every output is registered, responses are single-cycle pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last_grant <= FETCH;
      gnt_q <= FETCH;
      cnt <= '0;
      sz_q <= '0;
      lo_q <= '0;
      uns_q <= 1'b0;
      {if_ack, if_err, d_ack, d_err, ram_en, ram_rw, busy} <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
      ram_addr <= '0;
      ram_be <= '0;
      ram_wdata <= '0;
    end else begin
      {if_ack, if_err, d_ack, d_err} <= '0;
      case (state)
        IDLE: if (go) begin
          last_grant <= fetch_win ? FETCH : DATA;
          gnt_q <= fetch_win ? FETCH : DATA;
          if (bad) begin
            if_err <= fetch_win;
            d_err <= ~fetch_win;
          end else begin
            state <= ACCESS;
            busy <= 1'b1;
            ram_en <= 1'b1;
            cnt <= '0;
            ram_rw <= fetch_win | d_rw;
            ram_addr <= {fetch_win ? if_addr[31:2] : d_addr[31:2], 2'b00};
            ram_be <= be;
            ram_wdata <= lane_wdata;
            sz_q <= st_size;
            lo_q <= st_lo;
            uns_q <= d_unsigned;
          end
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (moc) begin
            state <= RELEASE;
            ram_en <= 1'b0;
            if (gnt_q == FETCH) begin
              if_ack <= 1'b1;
              if_rdata <= ram_rdata;
            end else begin
              d_ack <= 1'b1;
              if (ram_rw) d_rdata <= ld_data;
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state <= RELEASE;
            ram_en <= 1'b0;
            if_err <= gnt_q == FETCH;
            d_err <= gnt_q == DATA;
          end
        end
        RELEASE: if (!moc) begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_sequencer.sv
// tb_mem_bus_sequencer: directed self-checking bench for mem_bus_sequencer
module tb_mem_bus_sequencer;
  logic        clk = 1'b0, reset = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_rw = 1'b0, d_unsigned = 1'b0, moc = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, ram_rdata = '0;
  logic        if_ack, if_err, d_ack, d_err, ram_en, ram_rw, busy;
  logic [31:0] if_rdata, d_rdata, ram_addr, ram_wdata;
  logic [3:0]  ram_be;
  int          total = 0, bad = 0, n;

  mem_bus_sequencer #(.TIMEOUT(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_unsigned(d_unsigned), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_be(ram_be),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .moc(moc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_outs", {28'(0), if_ack, if_err, d_ack, d_err}, 32'h0);
    chk("rst_ram", {29'(0), ram_en, ram_rw, busy}, 32'h0);
    chk("rst_be", 32'(ram_be), 32'h0);
    chk("rst_rdata", if_rdata | d_rdata | ram_addr | ram_wdata, 32'h0);
    // fetch only
    if_addr = 32'h40; if_req = 1'b1;
    tick();
    chk("f_en", ram_en, 1); chk("f_be", ram_be, 4'hF); chk("f_rw", ram_rw, 1);
    chk("f_addr", ram_addr, 32'h40); chk("f_busy", busy, 1);
    tick();
    chk("f_noack2", if_ack, 0);
    tick();
    moc = 1'b1; ram_rdata = 32'h2008_0005;
    tick();
    chk("f_ack4", if_ack, 1); chk("f_rdata", if_rdata, 32'h2008_0005); chk("f_en_off", ram_en, 0);
    if_req = 1'b0; moc = 1'b0;
    tick();
    chk("f_ack_pulse", if_ack, 0); chk("f_idle", busy, 0);
    // conflict after reset: data first, then alternate
    reset = 1'b1;
    tick();
    reset = 1'b0;
    d_rw = 1'b1; d_size = 2'b00; d_addr = 32'h300; d_req = 1'b1; if_req = 1'b1;
    tick();
    chk("c1_data", ram_addr, 32'h300);
    moc = 1'b1; ram_rdata = 32'hAAAA_5555;
    tick();
    chk("c1_dack", d_ack, 1); chk("c1_noiack", if_ack, 0); chk("c1_drdata", d_rdata, 32'hAAAA_5555);
    d_req = 1'b0; moc = 1'b0;
    tick();
    chk("c2_idle", busy, 0);
    tick();
    chk("c2_fetch", ram_addr, 32'h40);
    d_req = 1'b1; moc = 1'b1; ram_rdata = 32'h1234_5678;
    tick();
    chk("c2_iack", if_ack, 1); chk("c2_irdata", if_rdata, 32'h1234_5678); chk("c2_nodack", d_ack, 0);
    moc = 1'b0;
    tick();
    tick();
    chk("c3_data", ram_addr, 32'h300);
    moc = 1'b1;
    tick();
    chk("c3_dack", d_ack, 1);
    if_req = 1'b0; d_req = 1'b0; moc = 1'b0;
    tick();
    // LB signed then unsigned
    d_rw = 1'b1; d_size = 2'b10; d_addr = 32'h103; d_unsigned = 1'b0; d_req = 1'b1;
    tick();
    chk("lb_be", ram_be, 4'b0001); chk("lb_addr", ram_addr, 32'h100);
    moc = 1'b1; ram_rdata = 32'h1122_33F0;
    tick();
    chk("lb_ack", d_ack, 1); chk("lb_sext", d_rdata, 32'hFFFF_FFF0);
    d_req = 1'b0; moc = 1'b0;
    tick();
    d_unsigned = 1'b1; d_req = 1'b1;
    tick();
    moc = 1'b1;
    tick();
    chk("lbu_zext", d_rdata, 32'h0000_00F0);
    d_req = 1'b0; moc = 1'b0;
    tick();
    // SH at 0x202
    d_rw = 1'b0; d_size = 2'b01; d_addr = 32'h202; d_wdata = 32'h0000_BEEF; d_req = 1'b1;
    tick();
    chk("sh_rw", ram_rw, 0); chk("sh_be", ram_be, 4'b0011);
    chk("sh_wdata", ram_wdata, 32'hBEEF_BEEF); chk("sh_addr", ram_addr, 32'h200);
    moc = 1'b1;
    tick();
    chk("sh_ack", d_ack, 1); chk("sh_rdata_hold", d_rdata, 32'h0000_00F0);
    d_req = 1'b0; moc = 1'b0;
    tick();
    // SB at 0x101
    d_size = 2'b10; d_addr = 32'h101; d_wdata = 32'h0000_005A; d_req = 1'b1;
    tick();
    chk("sb_be", ram_be, 4'b0100); chk("sb_wdata", ram_wdata, 32'h5A5A_5A5A);
    moc = 1'b1;
    tick();
    d_req = 1'b0; moc = 1'b0;
    tick();
    // misaligned word load
    d_rw = 1'b1; d_size = 2'b00; d_addr = 32'h202; d_req = 1'b1;
    tick();
    chk("mis_derr", d_err, 1); chk("mis_en", ram_en, 0); chk("mis_noack", d_ack, 0);
    d_req = 1'b0;
    tick();
    chk("mis_pulse", d_err, 0); chk("mis_en2", ram_en, 0); chk("mis_busy", busy, 0);
    // illegal size and misaligned fetch
    d_size = 2'b11; d_addr = 32'h100; d_req = 1'b1;
    tick();
    chk("ill_derr", d_err, 1);
    d_req = 1'b0; d_size = 2'b00;
    tick();
    if_addr = 32'h42; if_req = 1'b1;
    tick();
    chk("fmis_ierr", if_err, 1); chk("fmis_en", ram_en, 0);
    if_req = 1'b0;
    tick();
    chk("fmis_pulse", if_err, 0);
    // timeout with moc never asserted
    d_addr = 32'h400; d_req = 1'b1; n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ram_en) n++;
      if (d_err) break;
    end
    chk("to_derr", d_err, 1); chk("to_en_cycles", n, 16); chk("to_en_off", ram_en, 0); chk("to_noack", d_ack, 0);
    d_req = 1'b0;
    tick();
    chk("to_idle", busy, 0);
    // moc on the 16th cycle wins over timeout
    d_req = 1'b1;
    repeat (16) tick();
    chk("to16_en", ram_en, 1);
    moc = 1'b1; ram_rdata = 32'h0BAD_F00D;
    tick();
    chk("to16_ack", d_ack, 1); chk("to16_noerr", d_err, 0);
    moc = 1'b0; d_req = 1'b0;
    tick();
    // reset in ACCESS, then a fresh access
    d_addr = 32'h100; d_req = 1'b1;
    tick();
    chk("ra_en", ram_en, 1);
    reset = 1'b1;
    tick();
    chk("ra_en_off", ram_en, 0); chk("ra_busy", busy, 0); chk("ra_noresp", {30'(0), d_ack, d_err}, 0);
    reset = 1'b0;
    tick();
    chk("ra_new_en", ram_en, 1);
    moc = 1'b1; ram_rdata = 32'hCAFE_F00D;
    tick();
    chk("ra_new_ack", d_ack, 1); chk("ra_new_rdata", d_rdata, 32'hCAFE_F00D);
    d_req = 1'b0; moc = 1'b0;
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
